// File: rtl/fruit_pkg.sv
// rtl/fruit_pkg.sv - shared constants, fixed-point types and FSM encoding for fruit motion
package fruit_pkg;

    localparam int FRAC     = 4;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int POS_W = 12 + FRAC;
    localparam int VEL_W = 9 + FRAC;
    localparam int INT_W = POS_W - FRAC;

    typedef logic signed [POS_W-1:0] pos_t;
    typedef logic signed [VEL_W-1:0] vel_t;
    typedef logic signed [INT_W-1:0] int_t;

    localparam int_t X_LIM = int_t'(SCREEN_W);
    localparam int_t Y_LIM = int_t'(SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WHOLE,
        ST_SPLIT
    } state_t;

    function automatic int_t int_part(input pos_t p);
        return p[POS_W-1:FRAC];
    endfunction

endpackage

// File: rtl/half_integrator.sv
// rtl/half_integrator.sv - per-half position/velocity integrator with gravity, kick and death test
module half_integrator
    import fruit_pkg::*;
#(
    parameter int GRAVITY = 4,
    parameter int VY_MAX  = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  pos_t       load_x,
    input  pos_t       load_y,
    input  vel_t       load_vx,
    input  vel_t       load_vy,
    input  logic       kick,
    input  vel_t       kick_dv,
    input  logic       tick,
    input  logic       hold_alive,
    input  logic       alive_in,
    input  logic [8:0] half_w,
    output logic       alive_nxt,
    output logic       en,
    output logic [9:0] posx,
    output logic [9:0] posy
);

    pos_t       x_q, x_d, y_q, y_d;
    vel_t       vx_q, vx_d, vy_q, vy_d;
    vel_t       vx_k, vy_g;
    logic       alive_q, alive_d;
    logic       en_q, en_d;
    logic [9:0] posx_q, posx_d, posy_q, posy_d;
    int_t       x_int, y_int;
    logic signed [INT_W:0] right_edge;
    logic       dead;

    always_comb begin
        vx_k    = kick ? vx_q + kick_dv : vx_q;
        vy_g    = vy_q + vel_t'(GRAVITY);
        x_d     = x_q;
        y_d     = y_q;
        vx_d    = vx_k;
        vy_d    = vy_q;
        alive_d = alive_q;

        if (load) begin
            x_d     = load_x;
            y_d     = load_y;
            vx_d    = load_vx;
            vy_d    = load_vy;
            alive_d = 1'b1;
        end else if (tick && alive_q) begin
            // Position uses the velocity before this frame's gravity step.
            x_d  = x_q + pos_t'(vx_k);
            y_d  = y_q + pos_t'(vy_q);
            vy_d = (vy_g > vel_t'(VY_MAX)) ? vel_t'(VY_MAX) : vy_g;
        end

        x_int      = int_part(x_d);
        y_int      = int_part(y_d);
        right_edge = {x_int[INT_W-1], x_int} + $signed({{(INT_W+1-9){1'b0}}, half_w});
        dead       = (y_int >= Y_LIM) || right_edge[INT_W] || (right_edge == '0)
                     || (x_int >= X_LIM);

        if (!load && tick && alive_q) begin
            alive_d = hold_alive ? alive_in : !dead;
        end

        en_d   = alive_d && !x_d[POS_W-1] && !y_d[POS_W-1];
        posx_d = x_d[FRAC+9:FRAC];
        posy_d = y_d[FRAC+9:FRAC];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            alive_q <= 1'b0;
            en_q    <= 1'b0;
            posx_q  <= '0;
            posy_q  <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            alive_q <= alive_d;
            en_q    <= en_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
        end
    end

    assign alive_nxt = alive_d;
    assign en        = en_q;
    assign posx      = posx_q;
    assign posy      = posy_q;

endmodule

// File: rtl/fruit_split_motion.sv
// rtl/fruit_split_motion.sv - fruit flight FSM: whole flight, slice split, per-half drop-off
module fruit_split_motion
    import fruit_pkg::*;
#(
    parameter int GRAVITY  = 4,
    parameter int SPLIT_DV = 16,
    parameter int VY_MAX   = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [9:0] launch_x,
    input  logic [9:0] launch_y,
    input  logic [7:0] launch_vx,
    input  logic [7:0] launch_vy,
    input  logic       slice,
    input  logic [9:0] width,
    output logic       en1,
    output logic       en2,
    output logic [9:0] posx1,
    output logic [9:0] posx2,
    output logic [9:0] posy1,
    output logic [9:0] posy2,
    output logic       busy,
    output logic       done,
    output logic       sliced
);

    state_t     state_q, state_d;
    logic       done_q, done_d;
    logic       sliced_q, sliced_d;
    logic       launch_acc, slice_acc, hold2;
    logic       alive1_nxt, alive2_nxt;
    logic [8:0] half_w;
    pos_t       lx_fix, ly_fix, hw_fix;
    vel_t       lvx_fix, lvy_fix;

    assign half_w     = width[9:1];
    assign launch_acc = launch && (state_q == ST_IDLE);
    assign slice_acc  = slice && (state_q == ST_WHOLE);
    // While whole, half 2 runs the same integration offset by half_w; only
    // its liveness is slaved to half 1 so the unbroken fruit dies as one.
    assign hold2      = (state_q == ST_WHOLE) && !slice_acc;

    assign lx_fix  = pos_t'({launch_x, {FRAC{1'b0}}});
    assign ly_fix  = pos_t'({launch_y, {FRAC{1'b0}}});
    assign hw_fix  = pos_t'({half_w, {FRAC{1'b0}}});
    assign lvx_fix = vel_t'($signed({launch_vx, {FRAC{1'b0}}}));
    assign lvy_fix = vel_t'($signed({launch_vy, {FRAC{1'b0}}}));

    half_integrator #(.GRAVITY(GRAVITY), .VY_MAX(VY_MAX)) u_half1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (launch_acc),
        .load_x     (lx_fix),
        .load_y     (ly_fix),
        .load_vx    (lvx_fix),
        .load_vy    (lvy_fix),
        .kick       (slice_acc),
        .kick_dv    (vel_t'(-SPLIT_DV)),
        .tick       (frame_tick),
        .hold_alive (1'b0),
        .alive_in   (1'b0),
        .half_w     (half_w),
        .alive_nxt  (alive1_nxt),
        .en         (en1),
        .posx       (posx1),
        .posy       (posy1)
    );

    half_integrator #(.GRAVITY(GRAVITY), .VY_MAX(VY_MAX)) u_half2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (launch_acc),
        .load_x     (lx_fix + hw_fix),
        .load_y     (ly_fix),
        .load_vx    (lvx_fix),
        .load_vy    (lvy_fix),
        .kick       (slice_acc),
        .kick_dv    (vel_t'(SPLIT_DV)),
        .tick       (frame_tick),
        .hold_alive (hold2),
        .alive_in   (alive1_nxt),
        .half_w     (half_w),
        .alive_nxt  (alive2_nxt),
        .en         (en2),
        .posx       (posx2),
        .posy       (posy2)
    );

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        sliced_d = sliced_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d  = ST_WHOLE;
                    sliced_d = 1'b0;
                end
            end
            ST_WHOLE, ST_SPLIT: begin
                if (slice_acc) begin
                    state_d  = ST_SPLIT;
                    sliced_d = 1'b1;
                end
                if (!alive1_nxt && !alive2_nxt) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            sliced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            sliced_q <= sliced_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign sliced = sliced_q;

endmodule
